window_pixel_writer: RTL
========================

WINDOW_PIXEL_WRITER -- requirements
Module: window_pixel_writer

Interface
REQ-001 SHALL have parameter H_RES, default 480: panel width in pixels.
REQ-002 SHALL have parameter V_RES, default 272: panel height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 18: SRAM word address width.
REQ-004 SHALL have port mco, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_byte, input, 8: byte from the SPI slave.
REQ-007 SHALL have port i_dc, input, 1: 0 = command byte, 1 = data byte; qualified by i_byte_vld.
REQ-008 SHALL have port i_byte_vld, input, 1: one-cycle byte strobe.
REQ-009 SHALL have port o_wr_addr, output, ADDR_W: SRAM write address.
REQ-010 SHALL have port o_wr_data, output, 24: pixel {R8,G8,B8}.
REQ-011 SHALL have port o_wr_vld, output, 1: write request.
REQ-012 SHALL have port i_wr_rdy, input, 1: arbiter accepts the write when o_wr_vld & i_wr_rdy.
REQ-013 SHALL have port o_disp_on, output, 1: display enable level.
REQ-014 SHALL have port o_busy, output, 1: clear sweep in progress.
REQ-015 SHALL have port o_ovf_pls, output, 1: one-cycle pulse when a pixel is dropped.

Function
REQ-016 SHALL implement states IDLE, PARAM, RAMWR and CLEAR.
REQ-017 SHALL make command bytes take effect in any state except CLEAR, and SHALL make a command byte abort PARAM or RAMWR.
REQ-018 SHALL decode the commands as follows:
- 0x01: go to CLEAR and set o_disp_on=0.
- 0x28: set o_disp_on=0.
- 0x29: set o_disp_on=1.
- 0x2A, 0x2B, 0x3A: go to PARAM.
- 0x2C: load the cursor to (XS,YS) and go to RAMWR.
- Any other byte: go to IDLE.
REQ-019 SHALL collect 0x2A/0x2B parameters as 4 big-endian bytes (start hi, start lo, end hi, end lo), commit only on the 4th byte, discard partial sequences, and return to IDLE after commit.
REQ-020 SHALL reject a window with start > end: registers remain unchanged.
REQ-021 SHALL treat 0x3A parameter byte low nibble 0x5 as RGB565 (2 bytes/pixel) and 0x6 as RGB666 (3 bytes/pixel, upper 6 bits of each byte); SHALL ignore other values.
REQ-022 SHALL expand RGB565 as R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}, and RGB666 as C8={C6,C6[5:4]}.
REQ-023 SHALL, in RAMWR, assemble data bytes into a pixel and register o_wr_vld=1 on the cycle after the final pixel byte strobe.
REQ-024 SHALL compute o_wr_addr = (y*H_RES + x) truncated to ADDR_W bits.
REQ-025 SHALL advance the cursor once per completed pixel: if x==XE then x=XS and (y==YE ? y=YS : y+1); else x+1.
REQ-026 SHALL hold o_wr_vld, o_wr_addr and o_wr_data stable until accepted, and SHALL deassert o_wr_vld the cycle after acceptance unless a new pixel is loaded.
REQ-027 SHALL, when a pixel completes while o_wr_vld & ~i_wr_rdy, drop that pixel, pulse o_ovf_pls, and still advance the cursor.
REQ-028 SHALL, in CLEAR, write 0x000000 to addresses 0..H_RES*V_RES-1 in order, one per accepted handshake.
REQ-029 SHALL hold o_busy=1 during CLEAR, ignore all input bytes during CLEAR, and enter IDLE the cycle after the last write is accepted.
REQ-030 SHALL let a pending pixel write complete after an abort by a command byte, with no change to its address or data.

Reset
REQ-031 SHALL, while rst_n=0, drive all outputs to 0, set state IDLE, format RGB565, window X 0..H_RES-1, Y 0..V_RES-1, and cursor (0,0).
REQ-032 SHALL abort CLEAR and any pending write immediately on rst_n assertion, and SHALL not resume either after release.

Configuration
REQ-033 SHALL, when macro WINDOW_CLIP_EN is defined, consume pixels with x>=H_RES or y>=V_RES, advance the cursor, and issue no write.
REQ-034 SHALL, when WINDOW_CLIP_EN is undefined, write every pixel at the truncated address of REQ-024.

Verification
REQ-035 SHALL cover: 0x2A 00 0A 00 0B, 0x2B 00 05 00 05, 0x2C, four RGB565 pixels 0xF800 -> addresses 2410, 2411, 2410, 2411; data 0xFF0000.
REQ-036 SHALL cover: 0x3A 0x06, 0x2C, bytes FC 00 FC -> data 0xFF00FF at address 0.
REQ-037 SHALL cover: i_wr_rdy held 0 across two pixels -> one o_ovf_pls; second pixel's address skipped; first write held stable.
REQ-038 SHALL cover: 0x01 with i_wr_rdy=1 -> o_busy high for 130560 accepted writes of 0 at addresses 0..130559; o_disp_on=0.
REQ-039 SHALL cover: 0x2A 00 05 00 02 -> window unchanged; 0x2A 00 01 then 0x2C -> window unchanged.
REQ-040 SHALL cover: with WINDOW_CLIP_EN defined, X window 478..481 and four pixels -> writes only at x=478 and x=479.

Source files
------------

// File: rtl/window_pixel_writer.sv
// window_pixel_writer: decodes SPI display command/data bytes into windowed SRAM pixel writes and a clear sweep.
// Optional macro WINDOW_CLIP_EN: pixels outside the panel are consumed without issuing a write.
module window_pixel_writer #(
   parameter int H_RES  = 480,
   parameter int V_RES  = 272,
   parameter int ADDR_W = 18
) (
   input  logic              mco,
   input  logic              rst_n,
   input  logic [7:0]        i_byte,
   input  logic              i_dc,
   input  logic              i_byte_vld,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [23:0]       o_wr_data,
   output logic              o_wr_vld,
   input  logic              i_wr_rdy,
   output logic              o_disp_on,
   output logic              o_busy,
   output logic              o_ovf_pls
);
   localparam logic [31:0] TOTAL = 32'(H_RES * V_RES);

   typedef enum logic [1:0] {IDLE, PARAM, RAMWR, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [23:0]       pbuf_q, pbuf_d;
   logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [15:0]       x_q, x_d, y_q, y_d;
   logic              fmt666_q, fmt666_d;
   logic [31:0]       clr_q, clr_d;
   logic              wr_vld_q, wr_vld_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [23:0]       wr_data_q, wr_data_d;
   logic              disp_q, disp_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic              last, clip;
   logic [15:0]       nx, ny, p16;
   logic [23:0]       pix;
   logic [ADDR_W-1:0] pix_addr;

   assign p16      = {pbuf_q[7:0], i_byte};
   assign pix      = fmt666_q
                   ? {pbuf_q[15:10], pbuf_q[15:14], pbuf_q[7:2], pbuf_q[7:6], i_byte[7:2], i_byte[7:6]}
                   : {p16[15:11], p16[15:13], p16[10:5], p16[10:9], p16[4:0], p16[4:2]};
   assign last     = fmt666_q ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
   assign pix_addr = ADDR_W'({16'd0, y_q} * 32'(H_RES) + {16'd0, x_q});
   assign nx       = (x_q == xe_q) ? xs_q : x_q + 16'd1;
   assign ny       = (x_q == xe_q) ? ((y_q == ye_q) ? ys_q : y_q + 16'd1) : y_q;

`ifdef WINDOW_CLIP_EN
   assign clip = (x_q >= 16'(H_RES)) || (y_q >= 16'(V_RES));
`else
   assign clip = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      pbuf_d    = pbuf_q;
      xs_d      = xs_q;
      xe_d      = xe_q;
      ys_d      = ys_q;
      ye_d      = ye_q;
      x_d       = x_q;
      y_d       = y_q;
      fmt666_d  = fmt666_q;
      clr_d     = clr_q;
      wr_vld_d  = wr_vld_q & ~i_wr_rdy;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      disp_d    = disp_q;
      ovf_d     = 1'b0;
      if (state_q == CLEAR) begin
         // a pixel write left pending by the 0x01 abort drains before the sweep starts
         if (!wr_vld_q || i_wr_rdy) begin
            if (clr_q < TOTAL) begin
               wr_vld_d  = 1'b1;
               wr_addr_d = ADDR_W'(clr_q);
               wr_data_d = 24'd0;
               clr_d     = clr_q + 32'd1;
            end else begin
               state_d = IDLE;
            end
         end
      end else if (i_byte_vld && !i_dc) begin
         cmd_d   = i_byte;
         cnt_d   = 2'd0;
         clr_d   = 32'd0;
         state_d = (i_byte == 8'h01) ? CLEAR
                 : (i_byte inside {8'h2A, 8'h2B, 8'h3A}) ? PARAM
                 : (i_byte == 8'h2C) ? RAMWR : IDLE;
         disp_d  = (i_byte == 8'h29) ? 1'b1 : (i_byte == 8'h01 || i_byte == 8'h28) ? 1'b0 : disp_q;
         if (i_byte == 8'h2C) begin
            x_d = xs_q;
            y_d = ys_q;
         end
      end else if (i_byte_vld && state_q == PARAM) begin
         pbuf_d = {pbuf_q[15:0], i_byte};
         cnt_d  = cnt_q + 2'd1;
         if (cmd_q == 8'h3A) begin
            state_d  = IDLE;
            fmt666_d = (i_byte[3:0] == 4'h6) ? 1'b1 : (i_byte[3:0] == 4'h5) ? 1'b0 : fmt666_q;
         end else if (cnt_q == 2'd3) begin
            state_d = IDLE;
            if (pbuf_q[23:8] <= p16) begin
               if (cmd_q == 8'h2A) begin
                  xs_d = pbuf_q[23:8];
                  xe_d = p16;
               end else begin
                  ys_d = pbuf_q[23:8];
                  ye_d = p16;
               end
            end
         end
      end else if (i_byte_vld && state_q == RAMWR) begin
         pbuf_d = {pbuf_q[15:0], i_byte};
         cnt_d  = cnt_q + 2'd1;
         if (last) begin
            cnt_d = 2'd0;
            x_d   = nx;
            y_d   = ny;
            if (!clip) begin
               if (wr_vld_q && !i_wr_rdy) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_vld_d  = 1'b1;
                  wr_addr_d = pix_addr;
                  wr_data_d = pix;
               end
            end
         end
      end
      busy_d = (state_d == CLEAR);
   end

   always_ff @(posedge mco or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_q     <= 8'd0;
         cnt_q     <= 2'd0;
         pbuf_q    <= 24'd0;
         xs_q      <= 16'd0;
         xe_q      <= 16'(H_RES - 1);
         ys_q      <= 16'd0;
         ye_q      <= 16'(V_RES - 1);
         x_q       <= 16'd0;
         y_q       <= 16'd0;
         fmt666_q  <= 1'b0;
         clr_q     <= 32'd0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 24'd0;
         disp_q    <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cnt_q     <= cnt_d;
         pbuf_q    <= pbuf_d;
         xs_q      <= xs_d;
         xe_q      <= xe_d;
         ys_q      <= ys_d;
         ye_q      <= ye_d;
         x_q       <= x_d;
         y_q       <= y_d;
         fmt666_q  <= fmt666_d;
         clr_q     <= clr_d;
         wr_vld_q  <= wr_vld_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         disp_q    <= disp_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_wr_vld  = wr_vld_q;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_data = wr_data_q;
   assign o_disp_on = disp_q;
   assign o_busy    = busy_q;
   assign o_ovf_pls = ovf_q;
endmodule
